// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/product handshake bundle for seq_mult.
//   master : upstream/downstream side (drives operands and out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, a)
// Signals:
//   in_valid/in_ready   operand handshake
//   x, y, is_signed     operands and mode (WIDE bits each)
//   out_valid/out_ready product handshake
//   a                   product (2*WIDE bits)
interface seq_mult_if #(
  parameter int WIDE = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDE-1:0]   x;
  logic [WIDE-1:0]   y;
  logic              is_signed;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDE-1:0] a;

  modport master (
    output in_valid, x, y, is_signed, out_ready,
    input  in_ready, out_valid, a
  );

  modport slave (
    input  in_valid, x, y, is_signed, out_ready,
    output in_ready, out_valid, a
  );
endinterface

// File: rtl/seq_mult.sv
// seq_mult: iterative signed/unsigned multiplier, 2*WIDE-bit exact product.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  seq_mult_if.slave (in_valid/in_ready, x, y, is_signed,
//        out_valid/out_ready, a)
// Build option:
//   MULT_RADIX4_EN  radix-4 Booth recoding, WIDE/2 steps (WIDE must be even).
//                   Undefined: radix-2 shift-add, WIDE steps.
module seq_mult #(
  parameter int WIDE = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus
);
  localparam int PW = 2 * WIDE;
`ifdef MULT_RADIX4_EN
  localparam int STEPS = WIDE / 2;
  localparam int YW    = WIDE + 1;  // y with an implicit 0 below the LSB
`else
  localparam int STEPS = WIDE;
  localparam int YW    = WIDE;
`endif
  localparam int CW = $clog2(STEPS) + 1;

  if (WIDE < 2) begin : g_bad_wide
    $error("seq_mult: WIDE must be >= 2");
  end
`ifdef MULT_RADIX4_EN
  if (WIDE % 2 != 0) begin : g_odd_wide
    $error("seq_mult: WIDE must be even with MULT_RADIX4_EN");
  end
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;   // x, extended to PW and pre-shifted
  logic [YW-1:0]   mplier_q, mplier_d; // y, consumed from the LSB end
  logic [CW-1:0]   cnt_q;
  logic            signed_q;
  logic [PW-1:0]   a_q;
  logic            accept, last_step;
  logic            in_ready_d, out_valid_d;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_step = (cnt_q == CW'(STEPS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (last_step)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_d  = (state_q == IDLE);
    out_valid_d = (state_q == DONE);
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_d;
  assign bus.a         = a_q;

  // One partial-product step
`ifdef MULT_RADIX4_EN
  logic [PW-1:0] pp, extra;
  always_comb begin
    pp = '0;
    case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    // Booth treats y as signed; unsigned y with its MSB set needs one more
    // digit (+1 at weight 2^WIDE), folded into the final step.
    extra    = (last_step && !signed_q && mplier_q[2]) ? (mcand_q << 2) : '0;
    acc_d    = acc_q + pp + extra;
    mcand_d  = mcand_q << 2;
    mplier_d = mplier_q >> 2;
  end
`else
  logic [PW-1:0] pp;
  always_comb begin
    pp = mplier_q[0] ? mcand_q : '0;
    // Signed y: the MSB carries negative weight.
    if (last_step && signed_q) acc_d = acc_q - pp;
    else                       acc_d = acc_q + pp;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
  end
`endif

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      a_q      <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      signed_q <= bus.is_signed;
      mcand_q  <= bus.is_signed ? {{WIDE{bus.x[WIDE-1]}}, bus.x}
                                : {{WIDE{1'b0}}, bus.x};
`ifdef MULT_RADIX4_EN
      mplier_q <= {bus.y, 1'b0};
`else
      mplier_q <= bus.y;
`endif
    end else if (state_q == CALC) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_q + CW'(1);
      if (last_step) a_q <= acc_d;
    end
  end
endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Iterative multi-cycle multiplier. Parametrised successor to the team's single-cycle combinational `top` multiplier.
- Computes a full-width 2*WIDE product of two WIDE-bit operands.
- Operand mode is selectable per transaction: signed (two's complement) or unsigned.
- Valid/ready handshakes on input and output, so it drops into a pipelined datapath where area matters more than latency.

Parameters:
- WIDE, 8: operand width in bits; must be >= 2, and even when MULT_RADIX4_EN is defined. Product width is 2*WIDE.

Ports:
- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand set x, y, is_signed is valid
- in_ready  out  1  block can accept operands
- x  in  WIDE  multiplicand
- y  in  WIDE  multiplier
- is_signed  in  1  1 = signed operands and product, 0 = unsigned
- out_valid  out  1  product on a is valid
- out_ready  in  1  consumer accepts product
- a  out  2*WIDE  product

Behaviour:
- Clock and reset (already decided): single clock clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, a=0, step counter=0, internal operand/accumulator registers=0.
- States:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On a rising edge with in_valid=1: latch x, y, is_signed; clear accumulator and counter; go to CALC.
  - CALC:
    - in_ready=0, out_valid=0.
    - One partial-product step per cycle: radix-2, one y bit per cycle, LSB first; WIDE steps.
    - Signed mode: partial products sign-extended to 2*WIDE; the step for y[WIDE-1] subtracts instead of adds.
    - After the last step, register the product into a and go to DONE.
  - DONE:
    - out_valid=1, in_ready=0, a held stable.
    - On a rising edge with out_ready=1: go to IDLE.
    - Result stays held while out_ready=0, for any number of cycles.
- Latency: out_valid rises exactly WIDE rising edges after the accepting edge (8 for WIDE=8). The DONE->IDLE transition costs one cycle, so the minimum initiation interval is WIDE+2 cycles.
- Arithmetic:
  - a is the exact product, modulo nothing: signed range fits in 2*WIDE bits, including (-2^(WIDE-1))^2.
  - Unsigned: a = x*y as unsigned 2*WIDE. Signed: a = $signed(x)*$signed(y) as two's complement 2*WIDE.
- Input sampling:
  - x, y, is_signed are sampled only on the accepting edge.
  - Changes during CALC/DONE have no effect.
  - in_valid outside IDLE is ignored; no queuing, and the upstream must hold in_valid until accepted.
- a retains the last product after the DONE->IDLE handshake until the next completion overwrites it. a is not cleared on accept.
- Reset mid-operation (CALC or DONE): immediate abort; outputs return to reset values asynchronously; no out_valid pulse for the aborted operation.
- Zero operands: no early termination; latency is fixed and data-independent.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro: MULT_RADIX4_EN.
- Defined:
  - Radix-4 Booth recoding of y, two bits per step, WIDE/2 steps.
  - Latency becomes WIDE/2 edges after accept; initiation interval WIDE/2+2.
  - Unsigned mode handles the extra top recoding digit inside the final step, with no added cycle.
  - Results identical to radix-2.
  - Elaboration-time error if WIDE is odd.
- Undefined: radix-2 shift-add as described above, latency WIDE.
- Ports, handshake and state machine are identical in both builds.

Test Plan:
- WIDE=8, signed, x=0x80 (-128), y=0x80 (-128) -> a=0x4000 (16384); out_valid exactly 8 edges after accept (4 with MULT_RADIX4_EN).
- WIDE=8, signed, x=0xFF (-1), y=0x7F (127) -> a=0xFF81 (-127). Same operands unsigned -> a=0x7E81 (32385).
- WIDE=8, unsigned, x=0xFF, y=0xFF -> a=0xFE01 (65025). Then hold out_ready=0 for 5 cycles -> out_valid=1 and a=0xFE01 stable, in_ready=0 throughout.
- Accept x=3, y=5 signed, then change x/y/is_signed every cycle during CALC and pulse in_valid -> a=0x000F, exactly one result produced, the extra in_valid ignored.
- Accept x=0x12, y=0x34, assert rst for 1 cycle at step 4 -> out_valid stays 0, a=0, in_ready=1 immediately. Next transaction x=0x12, y=0x34 unsigned -> a=0x03A8.
- 1000 random transactions, random is_signed and random out_ready backpressure, WIDE in {8, 13, 16} (even only for radix-4) -> every a matches the behavioural x*y model for the given mode.
